// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM read port, and buffers
// returned words (tagged with their PC) in a 2-entry FIFO toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_SIZE = 64000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam logic [31:0] LAST_ADDR = 32'(ROM_SIZE - 4);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  // Word-aligned and fully inside the ROM.
  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  entry_t      slot0, slot1;
  entry_t      slot0_n, slot1_n;
  logic [1:0]  count, count_n, remaining;
  logic        fault;

  logic        pop, flush, push, issue;
  logic [2:0]  credit;

  assign pop    = instr_valid & instr_ready;
  assign flush  = branch_valid & ~fault;
  assign push   = inflight & ~flush;
  // Words that would be buffered or in flight after this cycle's pop; an
  // issue is allowed only while that leaves room for its response.
  assign credit = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
  assign issue  = ~rst & ~fault & ~branch_valid & legal(pc) & (credit < 3'd2);

  assign rom_enable  = issue;
  assign rom_address = pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = slot0.word;
  assign instr_pc    = slot0.pc;
  assign fetch_fault = fault;

  // Next FIFO contents: slot0 is the head; pop shifts, push fills the first free slot.
  always_comb begin
    slot0_n   = slot0;
    slot1_n   = slot1;
    remaining = count - {1'b0, pop};
    count_n   = count;
    if (flush) begin
      count_n = 2'd0;
    end else begin
      if (pop) slot0_n = slot1;
      if (push) begin
        if (remaining == 2'd0) slot0_n = '{word: rom_data, pc: inflight_pc};
        else                   slot1_n = '{word: rom_data, pc: inflight_pc};
      end
      count_n = remaining + {1'b0, push};
    end
  end

  // PC, in-flight tracking, FIFO and sticky fault update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      slot0       <= '0;
      slot1       <= '0;
      count       <= 2'd0;
      fault       <= 1'b0;
    end else begin
      slot0 <= slot0_n;
      slot1 <= slot1_n;
      count <= count_n;
      if (issue) begin
        pc          <= pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
      if (flush) begin
        if (legal(branch_target)) pc <= branch_target;
        else                      fault <= 1'b1;
      end else if (~fault & ~legal(pc)) begin
        fault <= 1'b1;
      end
    end
  end

endmodule
